ser_sum_collect: RTL and testbench
==================================

Name: ser_sum_collect

Overview:
- Receiving end of the bit-serial adder datapath: takes the LSB-first sum bit stream plus the adder's carry-out and reassembles a WIDTH-bit parallel result.
- The result and its final carry are presented on a valid/ready output port.
- Sits directly downstream of the serial adder. Its start input is driven by the same pulse that parallel-loads the adder.
- A separate shift register and output register let the next frame be collected while the consumer still holds the previous result.

Parameters:
- WIDTH, 16, number of sum bits per frame (must be >= 2).
- CNT_W, $clog2(WIDTH), width of the bit counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; clears all state while low
- start  input  1  marks the cycle in which bit 0 of a new frame is on sum_in (same cycle as the adder's parallel load)
- sum_in  input  1  serial sum bit, LSB first
- cout_in  input  1  adder carry-out for the bit currently on sum_in
- res_ready  input  1  consumer accepts result this cycle
- res_valid  output  1  result/carry_out hold a completed frame
- result  output  WIDTH  assembled sum, bit i = i-th serial bit
- carry_out  output  1  cout_in sampled with bit WIDTH-1
- busy  output  1  a frame is being collected (SHIFT state)
- overrun  output  1  sticky: a completed frame was dropped
- clr_ovr  input  1  synchronous clear of overrun

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, shreg=0, result=0, carry_out=0, res_valid=0, overrun=0, busy=0.
- Shifter FSM states: IDLE, SHIFT. Each shift is shreg <= {sum_in, shreg[WIDTH-1:1]}.
- IDLE, start=1: shift, count<=1, go to SHIFT. IDLE, start=0: hold, ignore sum_in.
- SHIFT, start=0, count<WIDTH-1: shift, count++.
- SHIFT, start=0, count==WIDTH-1 (last bit): the frame completes.
  - Completed word = {sum_in, shreg[WIDTH-1:1]}; completed carry = cout_in.
  - Go to IDLE, count<=0.
- SHIFT, start=1 (including on the last bit): abort the current frame silently, with no overrun.
  - The current bit becomes bit 0 of the new frame; count<=1; stay in SHIFT.
- busy = (state==SHIFT).
- Output buffer, on frame completion:
  - If res_valid==0, or res_valid==1 with res_ready==1 in the same cycle: result<=word, carry_out<=carry, res_valid<=1 next cycle.
  - Else (res_valid=1, res_ready=0): the completed frame is discarded, result/carry_out are unchanged, overrun<=1.
- Handshake without completion: res_valid=1 and res_ready=1 -> res_valid<=0; result/carry_out keep their last values.
- res_ready while res_valid=0 has no effect.
- result and carry_out are stable while res_valid=1 and res_ready=0.
- Latency: start in cycle k with no abort -> res_valid high from cycle k+WIDTH.
- Back-to-back frames: start may be asserted in the cycle after the last bit. Throughput is 1 frame per WIDTH cycles.
- overrun is sticky until clr_ovr=1. If clr_ovr and a new overrun occur in the same cycle, set wins.
- Reset mid-frame: the partial frame is lost and no result is produced; behaviour resumes from IDLE after reset is released.

Decomposition:
- Package ser_pkg:
  - Default WIDTH constant shared with the serial adder.
  - Shifter state enum {IDLE, SHIFT}.
- One natural sub-module, ser_bit_counter:
  - CNT_W-bit counter with load-to-1 on start and increment otherwise.
  - Flags last = (count==WIDTH-1).
  - Asynchronous active-low reset.
- The shift register, output register and overrun logic stay in the top.

Test Plan:
- Frame 0x1234+0x0F0F: drive start in cycle 0, then sum bits of 0x2143 LSB-first with cout per bit, res_ready=1 -> res_valid rises at cycle 16, result=0x2143, carry_out=0, overrun=0.
- Frame 0xFFFF+0x0001: stream of 16 zeros, cout=1 on every bit -> result=0x0000, carry_out=1 at cycle 16.
- Back-to-back with res_ready=1: frames 0x00FF then 0xA5A5, second start in cycle 16 -> two results at cycles 16 and 32, no gap, overrun=0.
- Backpressure: res_ready=0, two frames complete (0x1111 then 0x2222):
  - result stays 0x1111 and overrun=1 after the second completion.
  - res_ready=1 -> res_valid=0 next cycle.
  - clr_ovr -> overrun=0.
- Restart: start at cycle 0, bits for 0xFFFF, start again at cycle 5 followed by 16 bits of 0x0003 -> a single result 0x0003 at cycle 21, overrun=0.
- Reset mid-frame: reset=0 asynchronously at cycle 7 of a frame -> all outputs 0 immediately. After release and a fresh 0x8001 frame -> result=0x8001.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the bit-serial adder datapath.
package ser_pkg;

  localparam int SER_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit position counter for serial frame collection; flags the final bit.
module ser_bit_counter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_count;

  // load wins over clear so a restart on the final bit begins a new frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(1);
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_last = (r_count == LAST_CNT);

endmodule

// File: rtl/ser_sum_collect.sv
// Reassembles an LSB-first serial sum plus carry into a parallel result,
// double-buffered behind a valid/ready output with sticky overrun.
module ser_sum_collect
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sum_in,
  input  logic             cout_in,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  shift_state_t     r_state;
  shift_state_t     w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_valid;
  logic             r_ovr;

  logic             w_shift;
  logic             w_load;
  logic             w_inc;
  logic             w_clr;
  logic             w_done;
  logic             w_last;
  logic             w_accept;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_inc  (w_inc),
    .i_clr  (w_clr),
    .o_last (w_last)
  );

  assign w_word = {sum_in, r_shreg[WIDTH-1:1]};

  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_inc   = 1'b0;
    w_clr   = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_shift = 1'b1;
          w_load  = 1'b1;
          w_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          // silent restart: current bit becomes bit 0 of the new frame
          w_shift = 1'b1;
          w_load  = 1'b1;
        end else if (w_last) begin
          w_shift = 1'b1;
          w_clr   = 1'b1;
          w_done  = 1'b1;
          w_next  = IDLE;
        end else begin
          w_shift = 1'b1;
          w_inc   = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
    end else begin
      r_state <= w_next;
      if (w_shift) r_shreg <= w_word;
    end
  end

  assign w_accept = w_done && (!r_valid || res_ready);
  assign w_drop   = w_done && r_valid && !res_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_result <= w_word;
        r_carry  <= cout_in;
        r_valid  <= 1'b1;
      end else if (r_valid && res_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (clr_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign res_valid = r_valid;
  assign result    = r_result;
  assign carry_out = r_carry;
  assign busy      = (r_state == SHIFT);
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_ser_sum_collect.sv
// Directed and randomized checks of ser_sum_collect against a frame-level model.
module tb_ser_sum_collect;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         sum_in = 1'b0;
  logic         cout_in = 1'b0;
  logic         res_ready = 1'b0;
  logic         clr_ovr = 1'b0;
  logic         res_valid;
  logic         carry_out;
  logic         busy;
  logic         overrun;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  // reference model: frame assembly from a bit list, plus a one-slot output buffer
  bit           m_coll;
  int           m_n;
  longint       m_acc;
  logic [W-1:0] e_res;
  bit           e_val;
  bit           e_car;
  bit           e_ovr;

  ser_sum_collect #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("res_valid", W'(res_valid), W'(e_val));
    chk("result",    result,        e_res);
    chk("carry_out", W'(carry_out), W'(e_car));
    chk("overrun",   W'(overrun),   W'(e_ovr));
    chk("busy",      W'(busy),      W'(m_coll));
  endtask

  task automatic model_reset();
    m_coll = 0; m_n = 0; m_acc = 0;
    e_res = '0; e_val = 0; e_car = 0; e_ovr = 0;
  endtask

  task automatic model_step();
    bit done;
    bit set_ovr;
    done = 0;
    if (start) begin
      m_coll = 1; m_acc = longint'(sum_in); m_n = 1;
    end else if (m_coll) begin
      m_acc = m_acc + (longint'(sum_in) << m_n);
      m_n++;
      if (m_n == W) begin done = 1; m_coll = 0; end
    end
    set_ovr = done && e_val && !res_ready;
    if (done && (!e_val || res_ready)) begin
      e_res = W'(m_acc); e_car = cout_in; e_val = 1;
    end else if (!done && e_val && res_ready) begin
      e_val = 0;
    end
    if (set_ovr) e_ovr = 1;
    else if (clr_ovr) e_ovr = 0;
  endtask

  task automatic cyc(input bit st, input bit s, input bit c, input bit rr, input bit clr);
    start = st; sum_in = s; cout_in = c; res_ready = rr; clr_ovr = clr;
    @(posedge clk);
    model_step();
    #1;
    chk_all();
  endtask

  function automatic logic [W-1:0] add_couts(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] cv;
    int unsigned  m;
    int unsigned  s;
    for (int i = 0; i < W; i++) begin
      m = (32'd1 << (i + 1)) - 32'd1;
      s = (32'(a) & m) + (32'(b) & m);
      cv[i] = s[i+1];
    end
    return cv;
  endfunction

  task automatic frame(input logic [W-1:0] word, input logic [W-1:0] couts, input bit rr);
    for (int i = 0; i < W; i++) cyc(i == 0, word[i], couts[i], rr, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ffff;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all();
    chk("rst_result", result, 16'h0000);
    reset = 1'b1;
    cyc(0, 1, 1, 1, 0);

    // 0x1234 + 0x0F0F
    a = 16'h1234; b = 16'h0F0F;
    frame(a + b, add_couts(a, b), 1'b1);
    chk("t1_valid", W'(res_valid), 16'h0001);
    chk("t1_result", result, 16'h2143);
    chk("t1_carry", W'(carry_out), 16'h0000);
    cyc(0, 0, 0, 1, 0);

    // 0xFFFF + 0x0001
    a = 16'hFFFF; b = 16'h0001;
    frame(a + b, add_couts(a, b), 1'b1);
    chk("t2_result", result, 16'h0000);
    chk("t2_carry", W'(carry_out), 16'h0001);
    cyc(0, 0, 0, 1, 0);

    // back-to-back
    frame(16'h00FF, 16'h0000, 1'b1);
    cyc(1, 1, 0, 1, 0);
    chk("t3_first", result, 16'h00FF);
    for (int i = 1; i < W; i++) cyc(0, 1'(16'hA5A5 >> i), 1'b0, 1'b1, 1'b0);
    chk("t3_second", result, 16'hA5A5);
    chk("t3_ovr", W'(overrun), 16'h0000);
    cyc(0, 0, 0, 1, 0);

    // backpressure
    frame(16'h1111, 16'h0000, 1'b0);
    frame(16'h2222, 16'h0000, 1'b0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_hold", result, 16'h1111);
    chk("t4_ovr", W'(overrun), 16'h0001);
    cyc(0, 0, 0, 1, 0);
    chk("t4_drain", W'(res_valid), 16'h0000);
    cyc(0, 0, 0, 0, 1);
    chk("t4_clr", W'(overrun), 16'h0000);

    // restart mid-frame
    ffff = 16'hFFFF;
    for (int i = 0; i < 5; i++) cyc(i == 0, ffff[i], 1'b0, 1'b1, 1'b0);
    frame(16'h0003, 16'h0000, 1'b1);
    cyc(0, 0, 0, 1, 0);
    chk("t5_result", result, 16'h0003);
    chk("t5_ovr", W'(overrun), 16'h0000);

    // async reset mid-frame
    for (int i = 0; i < 7; i++) cyc(i == 0, 1'b1, 1'b1, 1'b0, 1'b0);
    start = 0; sum_in = 1; res_ready = 0;
    #3 reset = 1'b0;
    #1;
    model_reset();
    chk_all();
    chk("t6_rst_result", result, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(0, 0, 0, 1, 0);
    frame(16'h8001, 16'h0000, 1'b1);
    chk("t6_result", result, 16'h8001);

    // randomized
    for (int n = 0; n < 600; n++) begin
      bit st;
      st = m_coll ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
      cyc(st, 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
